sdram_dm_cache: RTL and testbench

SDRAM_DM_CACHE -- requirements
Module: sdram_dm_cache

---
 rtl/sdram_cache_pkg.sv | 15 +
 rtl/cache_line_ram.sv | 44 ++++
 rtl/sdram_dm_cache.sv | 182 ++++++++++++++++++
 tb/tb_sdram_dm_cache.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_cache_pkg.sv
// rtl/sdram_cache_pkg.sv - shared parameters and state encoding for the SDRAM direct-mapped cache
package sdram_cache_pkg;

    localparam int DEFAULT_INDEX_BITS = 8;
    localparam int DEFAULT_ADDR_BITS  = 21;

    typedef enum logic [2:0] {
        ST_FLUSH  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_MEM_RD = 3'd3,
        ST_MEM_WR = 3'd4
    } cache_state_t;

endpackage

// File: rtl/cache_line_ram.sv
// rtl/cache_line_ram.sv - tag/valid/data line storage, one synchronous read port and one byte-enabled write port
module cache_line_ram #(
    parameter int INDEX_BITS = 8,
    parameter int TAG_BITS   = 13
) (
    input  logic                  clk,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic                  wr_valid,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [3:0]            wr_be,
    input  logic [31:0]           wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic                valid_mem [LINES];
    logic [TAG_BITS-1:0] tag_mem   [LINES];
    logic [31:0]         data_mem  [LINES];

    // Tag and valid are rewritten on every write; only data honours the byte enables.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            valid_mem[wr_index] <= wr_valid;
            tag_mem[wr_index]   <= wr_tag;
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    data_mem[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        rd_valid <= valid_mem[rd_index];
        rd_tag   <= tag_mem[rd_index];
        rd_data  <= data_mem[rd_index];
    end

endmodule

// File: rtl/sdram_dm_cache.sv
// rtl/sdram_dm_cache.sv - write-through, read-allocate direct-mapped cache in front of an SDRAM controller
module sdram_dm_cache
    import sdram_cache_pkg::*;
#(
    parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
    parameter int ADDR_BITS  = DEFAULT_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_valid,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [3:0]           cpu_wmask,
    input  logic [31:0]          cpu_din,
    output logic [31:0]          cpu_dout,
    output logic                 cpu_ready,
    output logic                 mem_valid,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [3:0]           mem_wmask,
    output logic [31:0]          mem_din,
    input  logic [31:0]          mem_dout,
    input  logic                 mem_ready
);

    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] LAST_INDEX = '1;

    cache_state_t state, state_next;

    logic [INDEX_BITS-1:0] flush_cnt;
    logic [ADDR_BITS-1:0]  req_addr;
    logic [3:0]            req_wmask;
    logic [31:0]           req_din;
    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  req_is_read;
    logic                  hit;

    logic [INDEX_BITS-1:0] ram_rd_index;
    logic                  ram_rd_valid;
    logic [TAG_BITS-1:0]   ram_rd_tag;
    logic [31:0]           ram_rd_data;
    logic                  ram_wr_en;
    logic [INDEX_BITS-1:0] ram_wr_index;
    logic                  ram_wr_valid;
    logic [TAG_BITS-1:0]   ram_wr_tag;
    logic [3:0]            ram_wr_be;
    logic [31:0]           ram_wr_data;

    assign req_index   = req_addr[INDEX_BITS-1:0];
    assign req_tag     = req_addr[ADDR_BITS-1:INDEX_BITS];
    assign req_is_read = (req_wmask == 4'h0);
    assign hit         = ram_rd_valid && (ram_rd_tag == req_tag);

    cache_line_ram #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_lines (
        .clk      (clk),
        .rd_index (ram_rd_index),
        .rd_valid (ram_rd_valid),
        .rd_tag   (ram_rd_tag),
        .rd_data  (ram_rd_data),
        .wr_en    (ram_wr_en),
        .wr_index (ram_wr_index),
        .wr_valid (ram_wr_valid),
        .wr_tag   (ram_wr_tag),
        .wr_be    (ram_wr_be),
        .wr_data  (ram_wr_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FLUSH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        ram_rd_index = cpu_addr[INDEX_BITS-1:0];
        ram_wr_en    = 1'b0;
        ram_wr_index = req_index;
        ram_wr_valid = 1'b1;
        ram_wr_tag   = req_tag;
        ram_wr_be    = 4'h0;
        ram_wr_data  = req_din;
        case (state)
            ST_FLUSH: begin
                ram_wr_en    = 1'b1;
                ram_wr_index = flush_cnt;
                ram_wr_valid = 1'b0;
                if (flush_cnt == LAST_INDEX) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cpu_valid && !cpu_ready) begin
                    state_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (req_is_read) begin
                    state_next = hit ? ST_IDLE : ST_MEM_RD;
                end else begin
                    // Write hit: byte enables merge the new bytes, the rest of the line is kept.
                    if (hit) begin
                        ram_wr_en = 1'b1;
                        ram_wr_be = req_wmask;
                    end
                    state_next = ST_MEM_WR;
                end
            end
            ST_MEM_RD: begin
                if (mem_ready) begin
                    ram_wr_en   = 1'b1;
                    ram_wr_be   = 4'hF;
                    ram_wr_data = mem_dout;
                    state_next  = ST_IDLE;
                end
            end
            ST_MEM_WR: begin
                if (mem_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_FLUSH;
        endcase
        // A fill racing a reset must not leave a valid line behind.
        if (reset) begin
            ram_wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt <= '0;
            cpu_ready <= 1'b0;
            mem_valid <= 1'b0;
            cpu_dout  <= 32'h0;
            mem_wmask <= 4'h0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                ST_FLUSH: flush_cnt <= flush_cnt + 1'b1;
                ST_IDLE: begin
                    if (cpu_valid && !cpu_ready) begin
                        req_addr  <= cpu_addr;
                        req_wmask <= cpu_wmask;
                        req_din   <= cpu_din;
                    end
                end
                ST_LOOKUP: begin
                    if (req_is_read && hit) begin
                        cpu_dout  <= ram_rd_data;
                        cpu_ready <= 1'b1;
                    end else begin
                        mem_valid <= 1'b1;
                        mem_addr  <= req_addr;
                        mem_wmask <= req_wmask;
                        mem_din   <= req_din;
                    end
                end
                ST_MEM_RD: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        cpu_dout  <= mem_dout;
                        cpu_ready <= 1'b1;
                    end
                end
                ST_MEM_WR: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        cpu_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_dm_cache.sv
// tb/tb_sdram_dm_cache.sv - randomized self-checking bench for sdram_dm_cache with a behavioural SDRAM
module tb_sdram_dm_cache;

    localparam int IB = 8;
    localparam int AB = 21;
    localparam int MEM_LAT = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_valid = 1'b0;
    logic [AB-1:0] cpu_addr = '0;
    logic [3:0]    cpu_wmask = 4'h0;
    logic [31:0]   cpu_din = 32'h0;
    logic [31:0]   cpu_dout;
    logic          cpu_ready;
    logic          mem_valid;
    logic [AB-1:0] mem_addr;
    logic [3:0]    mem_wmask;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout = 32'h0;
    logic          mem_ready = 1'b0;

    sdram_dm_cache #(.INDEX_BITS(IB), .ADDR_BITS(AB)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_valid (cpu_valid),
        .cpu_addr  (cpu_addr),
        .cpu_wmask (cpu_wmask),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_ready (cpu_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wmask (mem_wmask),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int a);
        return (a * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Behavioural SDRAM controller: fixed latency, one-cycle ready pulse.
    logic [31:0] sdram_mem [int];
    int          mem_txn = 0;
    bit          busy = 0;
    int          wait_cnt = 0;
    logic [AB-1:0] cap_addr;
    logic [3:0]    cap_wmask;
    logic [31:0]   cap_din;
    bit          bad_stable = 0;
    bit          bad_drop = 0;

    function automatic logic [31:0] sdram_rd(input int a);
        return sdram_mem.exists(a) ? sdram_mem[a] : init_word(a);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                busy = 0;
                mem_ready = 1'b0;
            end else if (mem_ready) begin
                mem_ready = 1'b0;
                busy = 0;
                if (mem_valid) bad_drop = 1;
            end else if (busy) begin
                if (!mem_valid || mem_addr !== cap_addr || mem_wmask !== cap_wmask ||
                    (cap_wmask != 4'h0 && mem_din !== cap_din)) bad_stable = 1;
                wait_cnt++;
                if (wait_cnt == MEM_LAT) begin
                    if (cap_wmask == 4'h0) begin
                        mem_dout = sdram_rd(int'(cap_addr));
                    end else begin
                        sdram_mem[int'(cap_addr)] = merge(sdram_rd(int'(cap_addr)), cap_din, cap_wmask);
                        mem_dout = 32'hBAD0BAD0;
                    end
                    mem_ready = 1'b1;
                end
            end else if (mem_valid) begin
                busy = 1;
                wait_cnt = 0;
                cap_addr = mem_addr;
                cap_wmask = mem_wmask;
                cap_din = mem_din;
                mem_txn++;
            end
        end
    end

    // Reference: expected memory image plus which tag each line currently holds.
    logic [31:0]   ref_mem [int];
    bit            m_valid [1<<IB];
    logic [AB-IB-1:0] m_tag [1<<IB];

    function automatic logic [31:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < (1<<IB); i++) m_valid[i] = 0;
    endtask

    task automatic do_access(input logic [AB-1:0] a, input logic [3:0] m, input logic [31:0] d,
                             input int budget, output int lat);
        int          idx;
        bit          hit;
        bit          to;
        int          mc0;
        logic [31:0] got;
        idx = int'(a) % (1<<IB);
        hit = m_valid[idx] && (m_tag[idx] == a[AB-1:IB]);
        mc0 = mem_txn;
        got = 32'h0;
        @(negedge clk);
        cpu_valid = 1'b1; cpu_addr = a; cpu_wmask = m; cpu_din = d;
        lat = 0; to = 1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            lat++;
            if (cpu_ready) begin
                to = 0;
                got = cpu_dout;
                break;
            end
        end
        @(negedge clk);
        cpu_valid = 1'b0; cpu_wmask = 4'h0;
        @(posedge clk); #1;
        check("timeout", 32'(to), 32'd0);
        check("ready_one_cycle", 32'(cpu_ready), 32'd0);
        if (m == 4'h0) begin
            check("rd_data", got, ref_rd(int'(a)));
            check("rd_mem_txn", 32'(mem_txn - mc0), hit ? 32'd0 : 32'd1);
            if (hit) check("hit_latency", 32'(lat), 32'd2);
            m_valid[idx] = 1;
            m_tag[idx] = a[AB-1:IB];
        end else begin
            ref_mem[int'(a)] = merge(ref_rd(int'(a)), d, m);
            check("wr_mem_txn", 32'(mem_txn - mc0), 32'd1);
        end
    endtask

    int lat;

    initial begin
        sdram_mem[16] = 32'hDEADBEEF;
        ref_mem[16] = 32'hDEADBEEF;
        clear_model();

        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_cpu_dout", cpu_dout, 32'h0);
        check("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Request held across the flush: must not complete before the flush ends.
        do_access(21'h000010, 4'h0, 32'h0, 1000, lat);
        check("flush_blocks", 32'(lat > 256), 32'd1);
        do_access(21'h000010, 4'h0, 32'h0, 200, lat);
        do_access(21'h000010, 4'h3, 32'h11112222, 200, lat);
        check("sdram_written", sdram_rd(16), 32'hDEAD2222);
        do_access(21'h000010, 4'h0, 32'h0, 200, lat);
        do_access(21'h000020, 4'hF, 32'hCAFEF00D, 200, lat);
        do_access(21'h000020, 4'h0, 32'h0, 200, lat);
        do_access(21'h000110, 4'h0, 32'h0, 200, lat);
        do_access(21'h000010, 4'h0, 32'h0, 200, lat);
        do_access(21'h000110, 4'h0, 32'h0, 200, lat);
        do_access(21'h000010, 4'h0, 32'h0, 200, lat);

        // Reset in the middle of a fill to the same line as a cached word.
        do_access(21'h000030, 4'h0, 32'h0, 200, lat);
        do_access(21'h000030, 4'h0, 32'h0, 200, lat);
        @(negedge clk);
        cpu_valid = 1'b1; cpu_addr = 21'h000130; cpu_wmask = 4'h0;
        for (int i = 0; i < 20 && !mem_valid; i++) begin
            @(posedge clk); #1;
        end
        check("midrd_mem_valid_seen", 32'(mem_valid), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_mem_valid", 32'(mem_valid), 32'd0);
        check("abort_cpu_ready", 32'(cpu_ready), 32'd0);
        @(negedge clk);
        cpu_valid = 1'b0;
        clear_model();
        @(negedge clk);
        reset = 1'b0;
        do_access(21'h000030, 4'h0, 32'h0, 1000, lat);
        check("reflush_blocks", 32'(lat > 256), 32'd1);
        do_access(21'h000130, 4'h0, 32'h0, 200, lat);

        for (int n = 0; n < 200; n++) begin
            logic [AB-1:0] a;
            logic [3:0]    m;
            a = AB'((($urandom_range(0, 3)) << IB) | $urandom_range(0, 7));
            m = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            do_access(a, m, $urandom, 200, lat);
        end

        check("mem_req_stable", 32'(bad_stable), 32'd0);
        check("mem_valid_drop", 32'(bad_drop), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
